imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream and assembles little-endian 32-bit words.
- Writes each word into the instruction memory write port, starting at BASE_ADDR.
- Holds the CPU (program_counter reset) until the whole image is written and its checksum is verified, replacing the fixed $readmemh preload with run-time loading.

Parameters:
DEPTH, 256, instruction memory size in words; a word count above this is rejected
BASE_ADDR, 32'h00000000, byte address of the first word written
CNT_W, 9, width of the word counters; must hold the value DEPTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; (re)starts a load from any state
s_valid  input  1  byte-stream valid
s_data  input  8  byte-stream data
s_ready  output  1  byte accepted on a clk edge when s_valid&&s_ready
wr_en  output  1  one-cycle instruction-memory write strobe
wr_addr  output  32  byte address, word aligned
wr_data  output  32  assembled instruction word
cpu_hold  output  1  1 = keep the CPU in reset
done  output  1  image loaded and checksum matched (level)
error  output  1  load failed (level, sticky until start or reset)
words_loaded  output  CNT_W  number of words written so far

Behaviour:
- Frame format, in order:
  - 4 length bytes, N, little-endian.
  - N×4 data bytes, little-endian per word.
  - 1 checksum byte: XOR of all data bytes only. For N=0 the checksum is 0x00.
- Reset (rst_n low, asynchronous): state IDLE; s_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, words_loaded=0; byte index, word counter and checksum accumulator cleared.
- States and transitions:
  - IDLE: s_ready=0. start → LEN.
  - LEN: s_ready=1. Shift in 4 bytes, byte 0 into bits [7:0]. On the 4th accepted byte:
    - N>DEPTH → ERR.
    - N==0 → CSUM.
    - else → DATA.
  - DATA: s_ready=1. Each byte is placed into lane index[1:0] and XORed into the checksum.
    - On the 4th byte of a word, the next cycle has wr_en=1 (exactly one cycle), wr_data = assembled word, wr_addr = BASE_ADDR + 4×word_index.
    - words_loaded increments in that same cycle.
    - After word N-1 is accepted → CSUM.
  - CSUM: s_ready=1. One byte accepted: equal to the accumulator → DONE, else → ERR.
  - DONE: s_ready=0, done=1, cpu_hold=0.
  - ERR: s_ready=0, error=1, cpu_hold=1.
- cpu_hold=1 in every state except DONE. It deasserts on the cycle DONE is entered.
- Write latency: 1 cycle from acceptance of a word's last byte to wr_en. The loader accepts a byte on every cycle; back-to-back words produce wr_en pulses 4 cycles apart.
- s_valid low for any number of cycles: state held, no partial word lost, no write.
- start in any state, including mid-frame:
  - Next cycle in LEN.
  - Counters, byte index, checksum and words_loaded cleared; done=0, error=0, cpu_hold=1.
  - A byte presented in the same cycle as start is not accepted.
- Words already written before an ERR remain in memory; cpu_hold keeps the CPU from executing them.
- rst_n assertion mid-frame: immediate return to the reset values; a write strobe in flight is dropped.
- Word count arithmetic: compare against N using CNT_W-bit counters. N is compared at full 32 bits against DEPTH before truncation. wr_addr wraps modulo 2^32 (unreachable for legal DEPTH).

Decomposition:
- Shared package imem_loader_pkg holds:
  - state encoding localparams (IDLE, LEN, DATA, CSUM, DONE, ERR, 3 bits);
  - LEN_BYTES=4;
  - WORD_BYTES=4.
- Sub-module word_assembler:
  - 2-bit byte index and 32-bit shift/lane register;
  - outputs word_complete and word;
  - clear input driven by start.
  - Reused for both the length field and the data words.

Test Plan:
- Load 2 words, bytes 02 00 00 00 | 93 00 50 00 | 33 81 10 00 | 61, s_valid held high → wr_en twice: (0x0, 0x00500093) then (0x4, 0x00108133); done=1, cpu_hold=0, words_loaded=2.
- Same frame with checksum 0x60 → both writes occur, then error=1, done=0, cpu_hold=1; a following start plus the correct frame → done=1.
- Length bytes 00 01 00 00 (N=256) succeeds with 256 writes, last at wr_addr 0x3FC. Length 01 01 00 00 (N=257) → ERR after the 4th length byte, no wr_en, s_ready=0.
- Frame 00 00 00 00 | 00 → DONE with no writes; checksum 0x01 instead → ERR.
- Random s_valid gaps of 0–5 cycles on the 2-word frame → identical writes and final state; no wr_en during gaps.
- start pulsed after 6 bytes of a frame, then the full frame sent → first write at 0x0 with the correct word, words_loaded restarts at 0. rst_n low for 1 cycle mid-word → all outputs at reset values immediately (asynchronously), cpu_hold=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------
// imem_loader_pkg : shared state encoding and frame constants
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

package imem_loader_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    LEN  = ST_LEN,
    DATA = ST_DATA,
    CSUM = ST_CSUM,
    DONE = ST_DONE,
    ERR  = ST_ERR
  } state_e;

  localparam int unsigned LEN_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
// ---------------------------------------------------------------
// word_assembler : packs bytes little-endian into a 32-bit word
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic        word_complete_o,
  output logic [31:0] word_o
);

  localparam int unsigned IDX_W = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      lanes_q, lanes_d;

  // word_o already contains the byte being accepted, so the consumer can
  // latch a complete word on the same edge as its last byte.
  always_comb begin
    word_o = lanes_q;
    word_o[8*idx_q +: 8] = byte_i;
    word_complete_o = en_i && (idx_q == LAST_IDX);
    idx_d   = idx_q;
    lanes_d = lanes_q;
    if (clear_i) begin
      idx_d   = '0;
      lanes_d = '0;
    end else if (en_i) begin
      idx_d   = idx_q + IDX_W'(1);
      lanes_d = word_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      lanes_q <= '0;
    end else begin
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------
// imem_loader : streams a checksummed program image into imem
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] words_q, words_d, n_q, n_d, words_inc;
  logic [7:0]       csum_q, csum_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic             accept, asm_en, asm_complete;
  logic [31:0]      asm_word, len_word, word_off;

  word_assembler u_asm (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear_i         (start),
    .en_i            (asm_en),
    .byte_i          (s_data),
    .word_complete_o (asm_complete),
    .word_o          (asm_word)
  );

  // A byte offered alongside start belongs to the aborted frame.
  assign accept    = s_valid && s_ready && !start;
  assign asm_en    = accept && ((state_q == LEN) || (state_q == DATA));
  assign len_word  = asm_word[8*LEN_BYTES-1:0];
  assign words_inc = words_q + CNT_W'(1);
  assign word_off  = {{(30-CNT_W){1'b0}}, words_q, 2'b00};

  always_comb begin
    state_d   = state_q;
    words_d   = words_q;
    n_d       = n_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    s_ready   = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    if (start) begin
      state_d = LEN;
      words_d = '0;
      n_d     = '0;
      csum_d  = '0;
    end else begin
      case (state_q)
        LEN: if (asm_complete) begin
          if (len_word > DEPTH_W) begin
            state_d = ERR;
          end else if (len_word == 32'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
            n_d     = len_word[CNT_W-1:0];
          end
        end
        DATA: if (accept) begin
          csum_d = csum_q ^ s_data;
          if (asm_complete) begin
            wr_en_d   = 1'b1;
            wr_data_d = asm_word;
            wr_addr_d = BASE_ADDR + word_off;
            words_d   = words_inc;
            if (words_inc == n_q) state_d = CSUM;
          end
        end
        CSUM: if (accept) state_d = (s_data == csum_q) ? DONE : ERR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      words_q   <= '0;
      n_q       <= '0;
      csum_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      words_q   <= words_d;
      n_q       <= n_d;
      csum_q    <= csum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign words_loaded = words_q;
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);
  assign cpu_hold     = (state_q != DONE);

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------
// tb_imem_loader : scoreboard bench for the instruction-memory loader
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned CNT_W = 9;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             s_valid = 1'b0;
  logic [7:0]       s_data = 8'h00;
  logic             s_ready, wr_en, cpu_hold, done, error;
  logic [31:0]      wr_addr, wr_data;
  logic [CNT_W-1:0] words_loaded;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] frame_w[$];
  logic [31:0] last_addr = 32'hFFFF_FFFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h required=no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_addr !== mon_e.a || wr_data !== mon_e.d) begin
          errors++;
          $display("FAIL write actual addr=%h data=%h required addr=%h data=%h",
                   wr_addr, wr_data, mon_e.a, mon_e.d);
        end
        last_addr = wr_addr;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    for (t = 0; t < 50 && !s_ready; t++) @(negedge clk);
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout actual=0 required=1 byte=%h", b);
    end else begin
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit junk);
    @(negedge clk);
    start = 1'b1;
    if (junk) begin
      s_valid = 1'b1;
      s_data  = 8'hFF;
    end
    @(negedge clk);
    start   = 1'b0;
    s_valid = 1'b0;
  endtask

  // Sends length, the words in frame_w (when the length is legal) and the
  // checksum, XORed with csum_flip to corrupt it on purpose.
  task automatic send_frame(input logic [31:0] nlen, input logic [7:0] csum_flip, input int maxgap);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h00;
    for (int i = 0; i < 4; i++) send_byte(nlen[8*i +: 8], $urandom_range(0, maxgap));
    if (nlen <= DEPTH) begin
      for (int k = 0; k < frame_w.size(); k++) begin
        w = frame_w[k];
        exp_q.push_back('{a: BASE + 32'(4 * k), d: w});
        for (int i = 0; i < 4; i++) begin
          cs = cs ^ w[8*i +: 8];
          send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
        end
      end
      send_byte(cs ^ csum_flip, $urandom_range(0, maxgap));
    end
  endtask

  task automatic check_done(input string tag, input logic [31:0] nwords);
    idle(2);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), nwords);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_err(input string tag, input logic [31:0] nwords);
    idle(2);
    chk({tag, "_error"}, {31'd0, error}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), nwords);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_two_words();
    frame_w.delete();
    frame_w.push_back(32'h0050_0093);
    frame_w.push_back(32'h0010_8133);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    rst_n = 1'b1;
    idle(2);
    chk("idle_s_ready", {31'd0, s_ready}, 32'd0);

    // Two-word frame, continuous stream: checksum 0x61
    load_two_words();
    pulse_start(1'b0);
    send_frame(32'd2, 8'h00, 0);
    check_done("two", 32'd2);
    chk("two_s_ready", {31'd0, s_ready}, 32'd0);

    // Bad checksum 0x60, then recovery
    pulse_start(1'b0);
    chk("restart_words", 32'(words_loaded), 32'd0);
    chk("restart_hold", {31'd0, cpu_hold}, 32'd1);
    send_frame(32'd2, 8'h01, 0);
    check_err("badcs", 32'd2);
    pulse_start(1'b0);
    chk("clr_error", {31'd0, error}, 32'd0);
    send_frame(32'd2, 8'h00, 0);
    check_done("recover", 32'd2);

    // Full-depth image
    frame_w.delete();
    for (int i = 0; i < 256; i++)
      frame_w.push_back({8'(i) ^ 8'h5A, 8'(i), 8'hC3, ~8'(i)});
    pulse_start(1'b0);
    send_frame(32'd256, 8'h00, 0);
    check_done("n256", 32'd256);
    chk("n256_last_addr", last_addr, 32'h0000_03FC);

    // Oversize length
    frame_w.delete();
    pulse_start(1'b0);
    send_frame(32'd257, 8'h00, 0);
    check_err("n257", 32'd0);

    // Empty image
    pulse_start(1'b0);
    send_frame(32'd0, 8'h00, 0);
    check_done("n0", 32'd0);
    pulse_start(1'b0);
    send_frame(32'd0, 8'h01, 0);
    check_err("n0bad", 32'd0);

    // Stalls of 0-5 cycles between bytes
    load_two_words();
    pulse_start(1'b0);
    send_frame(32'd2, 8'h00, 5);
    check_done("gaps", 32'd2);

    // Abort mid-frame with a byte offered in the start cycle
    pulse_start(1'b0);
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h93, 0); send_byte(8'h00, 0);
    pulse_start(1'b1);
    chk("abort_words", 32'(words_loaded), 32'd0);
    send_frame(32'd2, 8'h00, 0);
    check_done("abort", 32'd2);

    // Asynchronous reset mid-word
    pulse_start(1'b0);
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h93, 0); send_byte(8'h00, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("arst_wr_addr", wr_addr, 32'd0);
    chk("arst_wr_data", wr_data, 32'd0);
    chk("arst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_error", {31'd0, error}, 32'd0);
    chk("arst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    pulse_start(1'b0);
    send_frame(32'd2, 8'h00, 0);
    check_done("post_rst", 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
